// File: rtl/in_keys.sv
// Debounced key/coin input port with an Avalon-style slave register file.
// Raw lines are synchronised, debounced per bit, and rising edges are latched into a maskable interrupt.
module in_keys #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [WIDTH-1:0] writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] readdata,
    output logic             irq
);

    localparam int            CW     = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_TC = CW'(DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_RSVD   = 2'd1;
    localparam logic [1:0] ADDR_MASK   = 2'd2;
    localparam logic [1:0] ADDR_EDGE   = 2'd3;

    logic [WIDTH-1:0] in_norm;
    logic [WIDTH-1:0] sync1_q;
    logic [WIDTH-1:0] sync2_q;
    logic [WIDTH-1:0] stable_q;
    logic [WIDTH-1:0] stable_d;
    logic [WIDTH-1:0] stable_dly_q;
    logic [WIDTH-1:0] mismatch;
    logic [WIDTH-1:0] qual_q;
    logic [WIDTH-1:0] qual_d;
    logic [CW-1:0]    cnt_q [WIDTH];
    logic [CW-1:0]    cnt_d [WIDTH];
    logic [WIDTH-1:0] mask_q;
    logic [WIDTH-1:0] mask_d;
    logic [WIDTH-1:0] edge_q;
    logic [WIDTH-1:0] edge_d;
    logic [WIDTH-1:0] clr_bits;
    logic             wr_en;

    assign in_norm  = ACTIVE_LOW ? ~in_port : in_port;
    assign mismatch = sync2_q ^ stable_q;

    // qual_q delays the start of counting by one cycle after a fresh mismatch,
    // so a constant level lands on stable exactly DEBOUNCE_CYCLES+2 edges after sync1 samples it.
    always_comb begin
        stable_d = stable_q;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = cnt_q[i];
            if (!mismatch[i]) begin
                cnt_d[i] = '0;
            end else if (qual_q[i]) begin
                if (cnt_q[i] == CNT_TC) begin
                    stable_d[i] = sync2_q[i];
                    cnt_d[i]    = '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
        qual_d = sync2_q ^ stable_d;
    end

    assign wr_en    = chipselect & ~write_n;
    assign clr_bits = (wr_en && (address == ADDR_EDGE)) ? writedata : '0;

    // Set is ORed in after the clear so a coincident edge wins over write-1-clear.
    always_comb begin
        mask_d = mask_q;
        if (wr_en && (address == ADDR_MASK)) begin
            mask_d = writedata;
        end
        edge_d = (edge_q & ~clr_bits) | (stable_q & ~stable_dly_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q      <= '0;
            sync2_q      <= '0;
            stable_q     <= '0;
            stable_dly_q <= '0;
            qual_q       <= '0;
            mask_q       <= '0;
            edge_q       <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q      <= in_norm;
            sync2_q      <= sync1_q;
            stable_q     <= stable_d;
            stable_dly_q <= stable_q;
            qual_q       <= qual_d;
            mask_q       <= mask_d;
            edge_q       <= edge_d;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA: readdata = stable_q;
            ADDR_RSVD: readdata = '0;
            ADDR_MASK: readdata = mask_q;
            ADDR_EDGE: readdata = edge_q;
            default:   readdata = '0;
        endcase
    end

    assign irq = |(edge_q & mask_q);

endmodule

// File: tb/tb_in_keys.sv
// Directed plus randomised bench for in_keys (WIDTH=4, DEBOUNCE_CYCLES=4, ACTIVE_LOW=1)
// checked every cycle against a run-length reference model of the debounce rule.
module tb_in_keys;

    localparam int W = 4;
    localparam int D = 4;

    logic         clk;
    logic         reset;
    logic [1:0]   address;
    logic         chipselect;
    logic         write_n;
    logic [W-1:0] writedata;
    logic [W-1:0] in_port;
    logic [W-1:0] readdata;
    logic         irq;

    in_keys #(
        .WIDTH          (W),
        .DEBOUNCE_CYCLES(D),
        .ACTIVE_LOW     (1'b1)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .address   (address),
        .chipselect(chipselect),
        .write_n   (write_n),
        .writedata (writedata),
        .in_port   (in_port),
        .readdata  (readdata),
        .irq       (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: hist[j] is the pressed-level sample taken j+1 edges ago. A bit of
    // stable flips once the last D+1 samples that have reached sync2 all disagree with it.
    logic [W-1:0] hist [0:7];
    logic [W-1:0] m_stable;
    logic [W-1:0] m_rose;
    logic [W-1:0] m_edge;
    logic [W-1:0] m_mask;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] model_rd(input logic [1:0] a);
        case (a)
            2'd0:    return m_stable;
            2'd2:    return m_mask;
            2'd3:    return m_edge;
            default: return '0;
        endcase
    endfunction

    task automatic model_edge();
        logic [W-1:0] nst;
        logic [W-1:0] clr;
        logic         run;
        if (reset) begin
            for (int j = 0; j < 8; j++) hist[j] = '0;
            m_stable = '0;
            m_rose   = '0;
            m_edge   = '0;
            m_mask   = '0;
        end else begin
            nst = m_stable;
            for (int b = 0; b < W; b++) begin
                run = 1'b1;
                for (int j = 1; j <= D + 1; j++) begin
                    if (hist[j][b] == m_stable[b]) run = 1'b0;
                end
                if (run) nst[b] = ~m_stable[b];
            end
            clr = (chipselect && !write_n && address == 2'd3) ? writedata : '0;
            m_edge = (m_edge & ~clr) | m_rose;
            if (chipselect && !write_n && address == 2'd2) m_mask = writedata;
            m_rose   = nst & ~m_stable;
            m_stable = nst;
            for (int j = 7; j > 0; j--) hist[j] = hist[j-1];
            hist[0] = ~in_port;
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        chk("cyc_readdata", 8'(readdata), 8'(model_rd(address)));
        chk("cyc_irq", 8'(irq), 8'(|(m_edge & m_mask)));
    endtask

    task automatic rd(input logic [1:0] a, input logic [W-1:0] exp, input string tag);
        address = a;
        #1;
        chk(tag, 8'(readdata), 8'(exp));
    endtask

    task automatic wr(input logic [1:0] a, input logic [W-1:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        step();
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    int k;

    initial begin
        reset      = 1'b1;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        in_port    = 4'hF;
        for (int j = 0; j < 8; j++) hist[j] = '0;
        m_stable = '0; m_rose = '0; m_edge = '0; m_mask = '0;

        repeat (3) step();
        chk("rst_irq", 8'(irq), 8'd0);
        reset = 1'b0;
        repeat (3) step();
        rd(2'd0, 4'h0, "rst_addr0");
        rd(2'd2, 4'h0, "rst_addr2");
        rd(2'd3, 4'h0, "rst_addr3");
        chk("rst_irq_after", 8'(irq), 8'd0);

        // Key0 press: count edges from the sampling edge to the stable rise.
        address = 2'd0;
        in_port = 4'hE;
        step();
        k = 1;
        while (k <= 20) begin
            step();
            if (readdata[0]) break;
            k++;
        end
        chk("key0_rise_edges", 8'(k), 8'(D + 2));
        rd(2'd0, 4'h1, "key0_addr0");
        rd(2'd3, 4'h0, "key0_edge_not_yet");
        step();
        rd(2'd3, 4'h1, "key0_edge_set");

        // Glitch on key1 shorter than the debounce window.
        address = 2'd0;
        in_port = 4'hC; step();
        in_port = 4'hE; step();
        in_port = 4'hC; step();
        in_port = 4'hE;
        repeat (8) step();
        rd(2'd0, 4'h1, "glitch_stable");
        rd(2'd3, 4'h1, "glitch_edge");

        // Mask enables irq on a pending capture; clear drops it.
        wr(2'd2, 4'h1);
        chk("mask_irq_on", 8'(irq), 8'd1);
        wr(2'd3, 4'h1);
        chk("clr_irq_off", 8'(irq), 8'd0);
        rd(2'd3, 4'h0, "clr_addr3");

        // Release key0, re-press, and clear on the very edge the capture sets.
        address = 2'd0;
        in_port = 4'hF;
        k = 1;
        while (k <= 20) begin
            step();
            if (!readdata[0]) break;
            k++;
        end
        chk("key0_release_seen", 8'(k <= 20), 8'd1);
        in_port = 4'hE;
        k = 1;
        while (k <= 20) begin
            step();
            if (readdata[0]) break;
            k++;
        end
        chk("key0_repress_seen", 8'(k <= 20), 8'd1);
        wr(2'd3, 4'h1);
        rd(2'd3, 4'h1, "set_wins_edge");
        chk("set_wins_irq", 8'(irq), 8'd1);
        wr(2'd3, 4'hF);

        // Reset in the middle of a key2 debounce, key2 (and key0) held throughout.
        in_port = 4'hA;
        repeat (3) step();
        reset = 1'b1;
        repeat (2) step();
        rd(2'd0, 4'h0, "midrst_addr0");
        chk("midrst_irq", 8'(irq), 8'd0);
        reset   = 1'b0;
        address = 2'd0;
        k = 0;
        while (k <= 20) begin
            step();
            if (readdata[2]) break;
            k++;
        end
        chk("key2_rise_after_rst", 8'(k), 8'(D + 2));
        step();
        rd(2'd3, 4'h5, "key2_edge_after_rst");

        // Randomised traffic against the model.
        for (int c = 0; c < 1500; c++) begin
            for (int b = 0; b < W; b++) begin
                if ($urandom_range(5) == 0) in_port[b] = ~in_port[b];
            end
            address   = 2'($urandom_range(3));
            writedata = 4'($urandom);
            if ($urandom_range(3) == 0) begin
                chipselect = 1'b1;
                write_n    = 1'b0;
            end else begin
                chipselect = 1'($urandom_range(1));
                write_n    = 1'b1;
            end
            reset = ($urandom_range(199) == 0);
            step();
        end
        reset      = 1'b0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
